// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the memory macro.
// slave is the arbiter's view; master is the core-plus-memory side.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        busy;
  logic        grant_d;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, grant_d
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, grant_d
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and data
// load/store, one access at a time, with an issue/wait/respond sequence.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  localparam logic [3:0] WaitLoad = 4'(MEM_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic        pri_d_q, pri_d_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        grant_data;
  logic        in_access;

  always_comb begin
    state_d    = state_q;
    pri_d_d    = pri_d_q;
    wait_cnt_d = wait_cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_data = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.if_req || bus.d_req) begin
          // Under contention pri_d picks the winner; the loser gets priority next.
          grant_data = bus.d_req && (!bus.if_req || pri_d_q);
          owner_d    = grant_data;
          pri_d_d    = !grant_data;
          we_d       = grant_data && bus.d_we;
          addr_d     = grant_data ? bus.d_addr : bus.if_addr;
          wdata_d    = grant_data ? bus.d_wdata : 32'h0;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        wait_cnt_d = WaitLoad;
        state_d    = StWait;
      end
      StWait: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = StResp;
          if (!we_q) begin
            if (owner_q) begin
              d_rdata_d = bus.mem_rdata;
            end else begin
              if_rdata_d = bus.mem_rdata;
            end
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pri_d_q    <= 1'b1;
      wait_cnt_q <= 4'd0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      if_rdata_q <= 32'h0;
      d_rdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      pri_d_q    <= pri_d_d;
      wait_cnt_q <= wait_cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Address/data stay on the bus for the whole issue+wait window, zero otherwise.
  assign in_access     = (state_q == StIssue) || (state_q == StWait);
  assign bus.mem_en    = (state_q == StIssue);
  assign bus.mem_we    = (state_q == StIssue) && we_q;
  assign bus.mem_addr  = in_access ? addr_q : 32'h0;
  assign bus.mem_wdata = in_access ? wdata_q : 32'h0;

  assign bus.if_ready  = (state_q == StResp) && !owner_q;
  assign bus.d_ready   = (state_q == StResp) && owner_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.grant_d   = owner_q;

endmodule
